// File: rtl/demux8_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// demux8_dispatch_ctrl
//
// Purpose:
//   Accepts one upstream word at a time and presents it to one of eight
//   downstream channels through a 1:8 demux tree. The destination is either
//   taken from the word's address (mode=0) or picked round-robin among the
//   enabled channels (mode=1). A word is held until the selected channel
//   handshakes it. Addressed words that target a disabled channel are dropped
//   and counted in a saturating counter.
//
// Ports:
//   clk        : single clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   mode       : 0 = addressed dispatch, 1 = round-robin dispatch
//   en_mask    : per-channel enable, bit i enables channel i
//   in_valid   : upstream word available
//   in_ready   : controller accepts a word this cycle
//   in_data    : upstream word (DW bits)
//   in_dest    : destination channel, used only in addressed mode
//   sel        : demux select code (sel[2] drives the first stage)
//   out_valid  : one-hot presentation strobe, bit sel high while busy
//   out_ready  : per-channel downstream ready, only out_ready[sel] is used
//   out_data   : held word
//   busy       : high while a word is being presented
//   drop_cnt   : saturating count of dropped addressed words
// ---------------------------------------------------------------------------
module demux8_dispatch_ctrl #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic [7:0]    en_mask,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [2:0]    in_dest,
  output logic [2:0]    sel,
  output logic [7:0]    out_valid,
  input  logic [7:0]    out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic [7:0]    drop_cnt
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [2:0]    r_sel;
  logic [2:0]    w_sel_next;
  logic [DW-1:0] r_data;
  logic [DW-1:0] w_data_next;
  logic [2:0]    r_rr_ptr;
  logic [2:0]    w_rr_ptr_next;
  logic [7:0]    r_drop_cnt;
  logic [7:0]    w_drop_cnt_next;

  logic          w_accept;
  logic          w_handshake;
  logic [7:0]    w_rot_mask;
  logic [2:0]    w_rr_off;
  logic [2:0]    w_rr_pick;

  // Enable mask rotated so that bit k corresponds to channel rr_ptr+1+k.
  // The lowest set bit of the rotated mask is then the round-robin winner.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign w_rot_mask[gi] = en_mask[r_rr_ptr + 3'(gi + 1)];
    end
  endgenerate

  // Lowest-index priority encode: scanning downward lets the smallest set
  // offset overwrite any larger one.
  always_comb begin
    w_rr_off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (w_rot_mask[k]) begin
        w_rr_off = 3'(k);
      end
    end
  end

  assign w_rr_pick = r_rr_ptr + 3'd1 + w_rr_off;

  // In round-robin mode an empty mask leaves nowhere to send, so the
  // controller refuses words rather than accepting and stalling.
  assign in_ready    = (r_state == S_IDLE) && (mode ? (|en_mask) : 1'b1);
  assign w_accept    = in_valid && in_ready;
  assign w_handshake = (r_state == S_SEND) && out_ready[r_sel];

  always_comb begin
    w_state_next    = r_state;
    w_sel_next      = r_sel;
    w_data_next     = r_data;
    w_rr_ptr_next   = r_rr_ptr;
    w_drop_cnt_next = r_drop_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!mode) begin
            if (en_mask[in_dest]) begin
              w_sel_next   = in_dest;
              w_data_next  = in_data;
              w_state_next = S_SEND;
            end else if (r_drop_cnt != 8'hFF) begin
              w_drop_cnt_next = r_drop_cnt + 8'd1;
            end
          end else begin
            w_sel_next   = w_rr_pick;
            w_data_next  = in_data;
            w_state_next = S_SEND;
          end
        end
      end
      S_SEND: begin
        // rr_ptr tracks the last delivered channel in both modes so the
        // round-robin order continues from wherever the last word went.
        if (w_handshake) begin
          w_rr_ptr_next = r_sel;
          w_state_next  = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sel      <= 3'd0;
      r_data     <= '0;
      r_rr_ptr   <= 3'd7;
      r_drop_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_next;
      r_sel      <= w_sel_next;
      r_data     <= w_data_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_drop_cnt <= w_drop_cnt_next;
    end
  end

  generate
    for (gi = 0; gi < 8; gi++) begin : g_ov
      assign out_valid[gi] = (r_state == S_SEND) && (r_sel == 3'(gi));
    end
  endgenerate

  assign sel      = r_sel;
  assign out_data = r_data;
  assign busy     = (r_state == S_SEND);
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_demux8_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_demux8_dispatch_ctrl
//
// Purpose:
//   Self-checking bench for demux8_dispatch_ctrl. A behavioural model of the
//   dispatch rules runs alongside the DUT and a compare process checks every
//   output on every falling edge. Directed scenarios pin the model with
//   hand-computed literal expectations; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_demux8_dispatch_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [7:0]    en_mask;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [2:0]    in_dest;
  logic [2:0]    sel;
  logic [7:0]    out_valid;
  logic [7:0]    out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic [7:0]    drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  demux8_dispatch_ctrl #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .en_mask   (en_mask),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_init = 0;
  bit m_busy;
  int m_sel, m_data, m_rr, m_drop;

  function automatic bit m_in_ready();
    if (m_busy) return 1'b0;
    if (mode) return (en_mask != 8'h00);
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; m_busy = 0; m_sel = 0; m_data = 0; m_rr = 7; m_drop = 0;
    end else if (m_init) begin
      if (m_busy) begin
        if (out_ready[m_sel]) begin
          m_busy = 0;
          m_rr   = m_sel;
        end
      end else if (in_valid && m_in_ready()) begin
        if (!mode) begin
          if (en_mask[in_dest]) begin
            m_busy = 1; m_sel = int'(in_dest); m_data = int'(in_data);
          end else if (m_drop < 255) begin
            m_drop = m_drop + 1;
          end
        end else begin
          for (int k = 1; k <= 8; k++) begin
            if (en_mask[(m_rr + k) % 8]) begin
              m_sel = (m_rr + k) % 8;
              break;
            end
          end
          m_busy = 1; m_data = int'(in_data);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_init) begin
      chk("cyc_in_ready",  32'(in_ready),  32'(m_in_ready()));
      chk("cyc_out_valid", 32'(out_valid), m_busy ? (32'd1 << m_sel) : 32'd0);
      chk("cyc_sel",       32'(sel),       32'(m_sel));
      chk("cyc_out_data",  32'(out_data),  32'(m_data));
      chk("cyc_busy",      32'(busy),      32'(m_busy));
      chk("cyc_drop_cnt",  32'(drop_cnt),  32'(m_drop));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [2:0] rr_exp [4] = '{3'd2, 3'd5, 3'd7, 3'd2};

  initial begin
    rst = 1'b1; mode = 1'b0; en_mask = 8'h00; in_valid = 1'b0;
    in_data = '0; in_dest = 3'd0; out_ready = 8'h00;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_drop_cnt",  32'(drop_cnt),  32'h0);
    chk("rst_busy",      32'(busy),      32'h0);

    // Addressed routing to channel 5
    mode = 1'b0; en_mask = 8'hFF; out_ready = 8'hFF;
    in_valid = 1'b1; in_data = 8'hA5; in_dest = 3'd5;
    #1 chk("addr_in_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    chk("addr_out_valid", 32'(out_valid), 32'h20);
    chk("addr_sel",       32'(sel),       32'h5);
    chk("addr_out_data",  32'(out_data),  32'hA5);
    step();
    chk("addr_idle", 32'(busy), 32'h0);
    $display("addr: dest 5 data A5 delivered");

    // Drop counting and saturation
    en_mask = 8'hF0; in_valid = 1'b1; in_dest = 3'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("drop_no_valid", 32'(out_valid), 32'h0);
    end
    chk("drop_cnt3", 32'(drop_cnt), 32'd3);
    repeat (297) step();
    in_valid = 1'b0;
    chk("drop_cnt_sat", 32'(drop_cnt), 32'd255);
    $display("drop: 300 words dropped, drop_cnt=%0d", drop_cnt);

    // Round-robin skipping
    do_reset();
    mode = 1'b1; en_mask = 8'b1010_0100; out_ready = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h10 + i);
      #1 chk("rr_in_ready", 32'(in_ready), 32'h1);
      step();
      in_valid = 1'b0;
      chk("rr_sel", 32'(sel), 32'(rr_exp[i]));
      chk("rr_out_valid", 32'(out_valid), 32'd1 << rr_exp[i]);
      $display("rr: word %0d -> channel %0d", i, sel);
      step();
    end

    // Empty mask then single channel
    mode = 1'b1; en_mask = 8'h00; in_valid = 1'b1; in_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      #1 chk("empty_in_ready", 32'(in_ready), 32'h0);
      step();
    end
    chk("empty_busy", 32'(busy), 32'h0);
    en_mask = 8'h08;
    #1 chk("mask08_in_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    chk("mask08_sel",       32'(sel),       32'h3);
    chk("mask08_out_valid", 32'(out_valid), 32'h08);
    $display("empty mask: word routed to channel %0d after mask=08", sel);
    step();

    // Backpressure on channel 4
    mode = 1'b0; en_mask = 8'hFF; out_ready = 8'hEF;
    in_valid = 1'b1; in_data = 8'h3C; in_dest = 3'd4;
    step();
    in_data = 8'h77;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'h10);
      chk("bp_out_data",  32'(out_data),  32'h3C);
      #1 chk("bp_in_ready", 32'(in_ready), 32'h0);
      step();
    end
    out_ready = 8'hFF; in_valid = 1'b0;
    chk("bp_still_busy", 32'(busy), 32'h1);
    step();
    chk("bp_done", 32'(busy), 32'h0);
    $display("backpressure: 5 stall cycles, then completed");

    // Reset while presenting to channel 6
    do_reset();
    mode = 1'b0; en_mask = 8'hFF; out_ready = 8'h00;
    in_valid = 1'b1; in_data = 8'h99; in_dest = 3'd6;
    step();
    in_valid = 1'b0;
    chk("rs_pre_valid", 32'(out_valid), 32'h40);
    rst = 1'b1; out_ready = 8'hFF;
    step();
    rst = 1'b0;
    chk("rs_out_valid", 32'(out_valid), 32'h0);
    chk("rs_sel",       32'(sel),       32'h0);
    chk("rs_drop_cnt",  32'(drop_cnt),  32'h0);
    mode = 1'b1; en_mask = 8'hFF; in_valid = 1'b1; in_data = 8'h11;
    step();
    in_valid = 1'b0;
    chk("rs_rr_first", 32'(sel), 32'h0);
    $display("reset mid-send: next rr word to channel %0d", sel);
    step();

    // Randomized phase, checked by the per-cycle compare process
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       en_mask = 8'h00;
          1:       en_mask = 8'hFF;
          default: en_mask = 8'($urandom);
        endcase
      end
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = 8'($urandom);
      in_dest  = 3'($urandom_range(0, 7));
      for (int b = 0; b < 8; b++) out_ready[b] = ($urandom_range(0, 9) < 6);
      step();
    end
    rst = 1'b0; in_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
